// File: rtl/lutram_stream_reader.sv
// Streams LENGTH consecutive words out of a single-port LUTRAM as a valid/ready
// stream, hiding the RAM's one-cycle read latency behind a two-entry skid FIFO.
module lutram_stream_reader #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 784,
   parameter int DEPTH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DEPTH_BITS-1:0] base_addr,
   input  logic [DEPTH_BITS:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_read_en,
   output logic [DEPTH_BITS-1:0] ram_read_address,
   input  logic [WIDTH-1:0]      ram_read_data,
   input  logic                  ram_write_active,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [DEPTH_BITS-1:0] LAST_ADDR = DEPTH_BITS'(DEPTH - 1);

   // DEPTH need not be a power of two, so the wrap is an explicit compare.
   function automatic logic [DEPTH_BITS-1:0] wrap_inc(input logic [DEPTH_BITS-1:0] a);
      if (a == LAST_ADDR)
         return '0;
      else
         return a + DEPTH_BITS'(1);
   endfunction

   logic [1:0]            state;
   logic [DEPTH_BITS:0]   len_q;
   logic [DEPTH_BITS:0]   issued;
   logic [DEPTH_BITS:0]   beat_cnt;
   logic [DEPTH_BITS-1:0] addr_p0;
   logic                  done_q;

   logic                  rd_vld_p1;
   logic [WIDTH-1:0]      fifo_mem [0:1];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            fifo_cnt;

   logic                  pop;
   logic                  push;
   logic [2:0]            credit;
   logic                  issue;
   logic                  last_issue;
   logic                  last_beat;

   assign pop        = (fifo_cnt != 2'd0) && m_ready;
   assign push       = rd_vld_p1;
   // Occupancy after this cycle's pop, counting the read already in flight.
   assign credit     = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
   assign issue      = (state == S_RUN) && (issued < len_q) && !ram_write_active
                       && (credit < 3'd2);
   assign last_issue = issue && (issued == len_q - (DEPTH_BITS+1)'(1));
   assign last_beat  = (beat_cnt == len_q - (DEPTH_BITS+1)'(1));

   // Stage p0: address generation and read issue
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         len_q    <= '0;
         issued   <= '0;
         beat_cnt <= '0;
         addr_p0  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (pop)
            beat_cnt <= beat_cnt + (DEPTH_BITS+1)'(1);
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     len_q    <= length;
                     issued   <= '0;
                     beat_cnt <= '0;
                     addr_p0  <= base_addr;
                     state    <= S_RUN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (issue) begin
                  issued  <= issued + (DEPTH_BITS+1)'(1);
                  addr_p0 <= wrap_inc(addr_p0);
                  if (last_issue)
                     state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && last_beat) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Stage p1: read in flight, data lands in the skid FIFO next edge
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_p1 <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else begin
         rd_vld_p1 <= issue;
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= ram_read_data;
   end

   // Stage p2: FIFO head drives the stream
   assign m_valid          = (fifo_cnt != 2'd0);
   assign m_data           = m_valid ? fifo_mem[rd_ptr] : '0;
   assign m_last           = m_valid && last_beat;
   assign ram_read_en      = issue;
   assign ram_read_address = addr_p0;
   assign busy             = (state != S_IDLE);
   assign done             = done_q;

endmodule

// File: tb/tb_lutram_stream_reader.sv
// Scoreboard bench for lutram_stream_reader: a registered-read RAM model feeds
// the DUT, expected beats and read addresses are queued when a transfer starts.
module tb_lutram_stream_reader;

   localparam int WIDTH = 8;
   localparam int DEPTH = 784;
   localparam int DB    = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [DB-1:0]    base_addr;
   logic [DB:0]      length;
   logic             busy;
   logic             done;
   logic             ram_read_en;
   logic [DB-1:0]    ram_read_address;
   logic [WIDTH-1:0] ram_read_data;
   logic             ram_write_active;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   beat_t            exp_q [$];
   logic [DB-1:0]    addr_q [$];
   logic [WIDTH-1:0] mem [DEPTH];
   int               errors = 0;
   int               checks = 0;
   int               hs_count = 0;
   logic             done_due = 1'b0;
   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] stall_data = '0;
   beat_t            mon_e;
   logic             nd;

   always #5 clk = ~clk;

   lutram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_BITS(DB)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .base_addr        (base_addr),
      .length           (length),
      .busy             (busy),
      .done             (done),
      .ram_read_en      (ram_read_en),
      .ram_read_address (ram_read_address),
      .ram_read_data    (ram_read_data),
      .ram_write_active (ram_write_active),
      .m_data           (m_data),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_last           (m_last)
   );

   always @(posedge clk) begin
      if (ram_read_en)
         ram_read_data <= mem[ram_read_address];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Monitor: reads, beats, stalls and done timing, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            done_due   = 1'b0;
            stall_prev = 1'b0;
         end else begin
            check("done", done, done_due);
            nd = 1'b0;
            if (ram_write_active)
               check("rd_during_wr", ram_read_en, 0);
            if (ram_read_en) begin
               if (addr_q.size() == 0)
                  check("extra_read", ram_read_en, 0);
               else
                  check("rd_addr", ram_read_address, addr_q.pop_front());
            end
            if (stall_prev) begin
               check("stall_valid", m_valid, 1);
               check("stall_data", m_data, stall_data);
            end
            if (m_valid && m_ready) begin
               hs_count++;
               if (exp_q.size() == 0) begin
                  check("extra_beat", m_valid, 0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("beat_data", m_data, mon_e.data);
                  check("beat_last", m_last, mon_e.last);
                  nd = mon_e.last;
               end
            end
            if (start && !busy && length == '0)
               nd = 1'b1;
            done_due   = nd;
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input int base, input int len);
      beat_t e;
      start     = 1'b1;
      base_addr = DB'(base);
      length    = (DB+1)'(len);
      for (int i = 0; i < len; i++) begin
         e.data = mem[(base + i) % DEPTH];
         e.last = (i == len - 1);
         exp_q.push_back(e);
         addr_q.push_back(DB'((base + i) % DEPTH));
      end
      tick();
      start = 1'b0;
   endtask

   // pattern 1 toggles m_ready as 1,0,0 repeating.
   task automatic wait_idle(input int budget, input int pattern);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         if (pattern == 1)
            m_ready = (n % 3 == 0);
         tick();
         n++;
      end
      m_ready = 1'b1;
      check("idle_queue", exp_q.size(), 0);
      check("idle_busy", busy, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", ram_read_en, 0);
      check("rst_addr", ram_read_address, 0);
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_data", m_data, 0);
   endtask

   // start at cycle 0: read strobe in cycle 1, beats in cycles 3..6, done in 7.
   task automatic run_basic();
      start_xfer(5, 4);
      check("lat_rd_en_c1", ram_read_en, 1);
      for (int k = 1; k <= 7; k++) begin
         if (k > 1)
            tick();
         check("lat_valid", m_valid, (k >= 3 && k <= 6));
      end
      check("basic_done", done, 1);
      check("basic_busy", busy, 0);
      wait_idle(20, 0);
   endtask

   initial begin
      int h0;
      int n;
      for (int i = 0; i < DEPTH; i++)
         mem[i] = WIDTH'(i);
      rst              = 1'b1;
      start            = 1'b0;
      base_addr        = '0;
      length           = '0;
      ram_write_active = 1'b0;
      m_ready          = 1'b1;
      tick();
      tick();
      check_reset_outputs();
      rst = 1'b0;
      tick();

      run_basic();

      start_xfer(782, 4);
      wait_idle(50, 0);

      start_xfer(100, 6);
      wait_idle(100, 1);

      start_xfer(200, 8);
      tick();
      tick();
      ram_write_active = 1'b1;
      repeat (3) tick();
      ram_write_active = 1'b0;
      wait_idle(60, 0);

      start_xfer(0, 0);
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      repeat (4) tick();

      start_xfer(300, 4);
      tick();
      start     = 1'b1;
      base_addr = DB'(400);
      length    = (DB+1)'(3);
      tick();
      start = 1'b0;
      wait_idle(50, 0);

      start_xfer(20, 3);
      n = 0;
      while (!done && n < 50) begin
         tick();
         n++;
      end
      check("b2b_done", done, 1);
      start_xfer(30, 2);
      check("b2b_busy", busy, 1);
      wait_idle(50, 0);

      start_xfer(50, 8);
      h0 = hs_count;
      n  = 0;
      while (hs_count < h0 + 2 && n < 50) begin
         tick();
         n++;
      end
      check("midrst_beats", (hs_count >= h0 + 2), 1);
      rst = 1'b1;
      exp_q.delete();
      addr_q.delete();
      tick();
      rst = 1'b0;
      check_reset_outputs();
      repeat (4) tick();
      check("midrst_idle_valid", m_valid, 0);

      run_basic();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lutram_stream_reader.md
Name: lutram_stream_reader

Overview:
- Read-side master for a single-port distributed-RAM buffer, such as the weight/activation LUTRAMs in the MNIST datapath.
- On a start pulse it reads LENGTH consecutive words from a base address, wrapping modulo DEPTH.
- Absorbs the RAM's 1-cycle registered read latency and presents the words as a valid/ready stream with full backpressure and a last flag.
- Yields to the RAM's write port whenever a writer is active.

Parameters:
- WIDTH, 8, bits per RAM word and per stream beat.
- DEPTH, 784, number of RAM locations.
- DEPTH_BITS, 10, address width; must satisfy 2^DEPTH_BITS >= DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only when busy=0.
- base_addr  in  DEPTH_BITS  first address; must be < DEPTH.
- length  in  DEPTH_BITS+1  word count, 0..DEPTH.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.
- ram_read_en  out  1  read strobe to RAM.
- ram_read_address  out  DEPTH_BITS  read address to RAM.
- ram_read_data  in  WIDTH  RAM registered output; valid the cycle after ram_read_en.
- ram_write_active  in  1  RAM write port in use this cycle.
- m_data  out  WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  marks final beat.

Behaviour:
- Reset: busy=0, done=0, ram_read_en=0, ram_read_address=0, m_valid=0, m_last=0, m_data=0. FSM goes to IDLE; skid FIFO and in-flight flag are cleared. Reset mid-transfer aborts with no done pulse; a read in flight is discarded.
- FSM states:
  - IDLE: start=1 with length>0 latches base_addr/length, sets issue counter to 0, goes to RUN. start with length=0 pulses done next cycle and stays IDLE, with no beats.
  - RUN: issues reads. Goes to DRAIN in the cycle the last read is issued.
  - DRAIN: waits for the in-flight read and FIFO to empty. The last handshake moves to IDLE.
- start while busy=1 is ignored.
- Issue rule in cycle t: ram_read_en=1 iff all of the following hold:
  - state=RUN
  - issued<length
  - ram_write_active=0
  - (fifo_count + inflight - (m_valid & m_ready)) < 2
- ram_read_en is combinational on ram_write_active. The write port wins the shared RAM address, so a read must never be asserted alongside a write.
- Address: ram_read_address = (base_addr + issued) mod DEPTH. The wrap is computed by compare/subtract, not by power-of-2 truncation.
- Capture: inflight is set when ram_read_en=1. In the following cycle ram_read_data is pushed into a 2-entry FIFO and inflight is cleared. Push and pop in the same cycle are allowed; count is unchanged.
- Output: m_data/m_valid come from the FIFO head. m_data holds stable while m_valid=1 and m_ready=0.
- m_last=1 on the beat whose index equals length-1 (counted at pop).
- Latency: start accepted at edge E0 → ram_read_en in cycle 1 → m_valid in cycle 3.
- Throughput: 1 beat/cycle when m_ready=1 and ram_write_active=0.
- FIFO never overflows. Credit accounting guarantees count ≤ 2.
- Completion: the last handshake in cycle t gives done=1 and busy=0 in cycle t+1. A new start is accepted in cycle t+1.
- busy=1 in RUN and DRAIN.
- length=DEPTH: every location is read exactly once, including the wrap.

Test Plan:
- Basic: RAM[i]=i, base=5, length=4, m_ready=1 → beats 5,6,7,8 in consecutive cycles 3..6, m_last on 8, done in cycle 7.
- Wrap: DEPTH=784, base=782, length=4 → addresses 782,783,0,1, data in that order, m_last on word from address 1.
- Backpressure: length=6, m_ready toggling 1,0,0,1,... → no beat lost or duplicated, m_data stable during stalls, FIFO count never exceeds 2.
- Writer contention: ram_write_active=1 for 3 cycles mid-transfer → ram_read_en=0 in those cycles, address does not advance, output sequence intact.
- Edge lengths: length=0 → done one cycle later, no m_valid. start during busy → ignored. Back-to-back start in done cycle → accepted.
- Reset mid-transfer: rst after 2 of 8 beats → all outputs at reset values next cycle, no done. A new transfer then behaves as in the basic scenario.
